// File: rtl/mm_result_collector.sv
// -----------------------------------------------------------------------------
// mm_result_collector
//
// Collects result elements streamed out of the matrix multiplier, tags each one
// with its 0-based (row, col) position, an end-of-matrix marker and an
// illegal-result marker, and queues the tagged entries in a FIFO for the host.
//
// Every sample first lands in a one-entry staging register and is pushed into
// the FIFO on the following edge.  The one-cycle delay lets the collector see
// whether another legal sample follows: if none does, the staged element was
// the last of its matrix.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   mm_valid       result strobe from the multiplier
//   mm_data[19:0]  signed result element (two's complement)
//   mm_change_row  high with the last element of each result row
//   mm_is_legal    low together with mm_valid when the dimension check failed
//   out_ready      host accepts the head entry
//   out_valid      head entry available (fifo_count != 0)
//   out_data       head element value
//   out_row/col    head element position, 2 bits each
//   out_last       head entry ends a matrix
//   out_illegal    head entry reports a failed dimension check
//   fifo_count     FIFO occupancy, 0..DEPTH
//   overflow       sticky: an entry was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module mm_result_collector #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mm_valid,
    input  logic [19:0]                mm_data,
    input  logic                       mm_change_row,
    input  logic                       mm_is_legal,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [19:0]                out_data,
    output logic [1:0]                 out_row,
    output logic [1:0]                 out_col,
    output logic                       out_last,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    // Entry layout: {data[19:0], row[1:0], col[1:0], illegal, last}
    localparam int EW = 26;

    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Sample classification and push/pop decisions
    // -------------------------------------------------------------------------
    logic          legal_sample;
    logic          illegal_sample;
    logic          push;
    logic          push_last;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [EW-1:0] push_entry;

    // Staging register
    logic          stg_valid;
    logic [19:0]   stg_data;
    logic [1:0]    stg_row;
    logic [1:0]    stg_col;
    logic          stg_illegal;

    // Position counters
    logic [1:0]    row_cnt;
    logic [1:0]    col_cnt;

    // FIFO
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        legal_sample   = mm_valid & mm_is_legal;
        illegal_sample = mm_valid & ~mm_is_legal;
        push           = stg_valid;
        // The staged element closes its matrix unless a legal sample follows
        // directly behind it; an illegal entry is always a matrix by itself.
        push_last      = stg_illegal | ~legal_sample;
        push_entry     = {stg_data, stg_row, stg_col, stg_illegal, push_last};
        full           = (count == FULL_COUNT);
        pop            = (count != '0) & out_ready;
        // A pop in the same cycle frees the slot the push needs.
        wr_en          = push & (~full | pop);
        drop           = push & full & ~pop;
    end

    // -------------------------------------------------------------------------
    // Staging register: loads on every sample, empties when no sample arrives.
    // Its content is pushed on the edge after it was loaded.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // always_ff block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid   <= 1'b0;
            stg_data    <= '0;
            stg_row     <= '0;
            stg_col     <= '0;
            stg_illegal <= 1'b0;
        end else begin
            stg_valid <= mm_valid;
            if (legal_sample) begin
                stg_data    <= mm_data;
                stg_row     <= row_cnt;
                stg_col     <= col_cnt;
                stg_illegal <= 1'b0;
            end else if (illegal_sample) begin
                stg_data    <= '0;
                stg_row     <= '0;
                stg_col     <= '0;
                stg_illegal <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Row/column counters.  A legal sample advances the position; an illegal
    // sample or the push of a matrix-closing entry rewinds to (0,0).  The two
    // only coincide when an illegal entry is pushed while a legal sample
    // arrives; the counters are already at (0,0) then, so the sample's
    // advance wins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (legal_sample) begin
            if (mm_change_row) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 2'd1;
            end else begin
                col_cnt <= col_cnt + 2'd1;
            end
        end else if (illegal_sample || (push && push_last)) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Head outputs.  Gated with out_valid so they read 0 whenever the FIFO is
    // empty, including throughout reset.
    // -------------------------------------------------------------------------
    always_comb begin
        head        = mem[rd_ptr];
        out_valid   = (count != '0);
        fifo_count  = count;
        out_data    = '0;
        out_row     = '0;
        out_col     = '0;
        out_illegal = 1'b0;
        out_last    = 1'b0;
        if (out_valid) begin
            out_data    = head[25:6];
            out_row     = head[5:4];
            out_col     = head[3:2];
            out_illegal = head[1];
            out_last    = head[0];
        end
    end

endmodule

// File: tb/tb_mm_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mm_result_collector
//
// Directed bench for mm_result_collector.  A per-cycle vector table covers the
// 2x2 frame, illegal samples and ignored change_row; hand-written sequences
// cover backpressure, full-with-pop, overflow and reset mid-frame.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that the inputs were sampled on.
// -----------------------------------------------------------------------------
module tb_mm_result_collector;

    logic        clk;
    logic        rst_n;
    logic        mm_valid;
    logic [19:0] mm_data;
    logic        mm_change_row;
    logic        mm_is_legal;
    logic        out_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_illegal;
    logic [4:0]  fifo_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    mm_result_collector #(.DEPTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mm_valid      (mm_valid),
        .mm_data       (mm_data),
        .mm_change_row (mm_change_row),
        .mm_is_legal   (mm_is_legal),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_last      (out_last),
        .out_illegal   (out_illegal),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        legal;
        logic        cr;
        logic        rdy;
        logic [19:0] data;
        logic        ev;
        logic [19:0] ed;
        logic [1:0]  er;
        logic [1:0]  ec;
        logic        el;
        logic        ei;
        logic [4:0]  ecnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_head(input string tag, input logic [19:0] d, input logic [1:0] r,
                              input logic [1:0] c, input logic l, input logic il);
        check({tag, " valid"},   {31'd0, out_valid},   32'd1);
        check({tag, " data"},    {12'd0, out_data},    {12'd0, d});
        check({tag, " row"},     {30'd0, out_row},     {30'd0, r});
        check({tag, " col"},     {30'd0, out_col},     {30'd0, c});
        check({tag, " last"},    {31'd0, out_last},    {31'd0, l});
        check({tag, " illegal"}, {31'd0, out_illegal}, {31'd0, il});
    endtask

    // Sends a rows x cols frame of values base, base+1, ... followed by one
    // idle cycle so the final element gets pushed with last=1.
    task automatic send_frame(input int rows, input int cols, input int base, input logic rdy);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                mm_valid      = 1'b1;
                mm_is_legal   = 1'b1;
                mm_data       = 20'(base + r * cols + c);
                mm_change_row = (c == cols - 1);
                out_ready     = rdy;
                @(negedge clk);
            end
        end
        mm_valid      = 1'b0;
        mm_change_row = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mm_valid      = 1'b0;
        mm_is_legal   = 1'b1;
        mm_change_row = 1'b0;
        mm_data       = '0;
    endtask

    initial begin
        // ---------------- vector table ----------------
        //          v  L  cr rdy data        ev ed          er ec el ei cnt
        vecs[0]  = '{1, 1, 0, 1, 20'd5,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[1]  = '{1, 1, 1, 1, -20'sd3,     1, 20'd5,       0, 0, 0, 0, 5'd1};
        vecs[2]  = '{1, 1, 0, 1, 20'd7,       1, -20'sd3,     0, 1, 0, 0, 5'd1};
        vecs[3]  = '{1, 1, 1, 1, 20'd9,       1, 20'd7,       1, 0, 0, 0, 5'd1};
        vecs[4]  = '{0, 1, 0, 1, 20'd0,       1, 20'd9,       1, 1, 1, 0, 5'd1};
        vecs[5]  = '{0, 1, 0, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[6]  = '{1, 0, 0, 1, 20'd123,     0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[7]  = '{0, 1, 0, 1, 20'd0,       1, 20'd0,       0, 0, 1, 1, 5'd1};
        vecs[8]  = '{0, 1, 0, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[9]  = '{0, 1, 1, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[10] = '{0, 1, 0, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[11] = '{1, 1, 0, 0, 20'd100,     0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[12] = '{0, 1, 0, 0, 20'd0,       1, 20'd100,     0, 0, 1, 0, 5'd1};
        vecs[13] = '{0, 1, 0, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[14] = '{1, 1, 0, 0, 20'd11,      0, 20'd0,       0, 0, 0, 0, 5'd0};
        vecs[15] = '{1, 0, 0, 0, 20'd55,      1, 20'd11,      0, 0, 1, 0, 5'd1};
        vecs[16] = '{1, 1, 0, 0, 20'd22,      1, 20'd11,      0, 0, 1, 0, 5'd2};
        vecs[17] = '{0, 1, 0, 1, 20'd0,       1, 20'd0,       0, 0, 1, 1, 5'd2};
        vecs[18] = '{0, 1, 0, 1, 20'd0,       1, 20'd22,      0, 0, 1, 0, 5'd1};
        vecs[19] = '{0, 1, 0, 1, 20'd0,       0, 20'd0,       0, 0, 0, 0, 5'd0};

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("reset out_valid",  {31'd0, out_valid},  32'd0);
        check("reset fifo_count", {27'd0, fifo_count}, 32'd0);
        check("reset overflow",   {31'd0, overflow},   32'd0);
        check("reset out_data",   {12'd0, out_data},   32'd0);
        check("reset out_flags",  {28'd0, out_row, out_col} | {30'd0, out_last, out_illegal}, 32'd0);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < NVEC; k++) begin
            mm_valid      = vecs[k].v;
            mm_is_legal   = vecs[k].legal;
            mm_change_row = vecs[k].cr;
            out_ready     = vecs[k].rdy;
            mm_data       = vecs[k].data;
            @(negedge clk);
            check($sformatf("vec%0d out_valid", k),  {31'd0, out_valid},  {31'd0, vecs[k].ev});
            check($sformatf("vec%0d fifo_count", k), {27'd0, fifo_count}, {27'd0, vecs[k].ecnt});
            if (vecs[k].ev) begin
                check_head($sformatf("vec%0d", k), vecs[k].ed, vecs[k].er, vecs[k].ec,
                           vecs[k].el, vecs[k].ei);
            end
        end
        idle_inputs();

        // ---------------- backpressure: 4x4 frame held ----------------
        send_frame(4, 4, 1, 1'b0);
        check("bp fifo_count", {27'd0, fifo_count}, 32'd16);
        check("bp overflow",   {31'd0, overflow},   32'd0);
        for (int i = 0; i < 3; i++) begin
            check_head($sformatf("bp hold%0d", i), 20'd1, 2'd0, 2'd0, 1'b0, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_head($sformatf("bp pop%0d", i), 20'(i + 1), 2'(i / 4), 2'(i % 4),
                       (i == 15), 1'b0);
            @(negedge clk);
        end
        check("bp drained", {27'd0, fifo_count}, 32'd0);

        // ---------------- full with simultaneous push and pop ----------------
        send_frame(4, 4, 200, 1'b0);
        check("fp fill", {27'd0, fifo_count}, 32'd16);
        mm_valid    = 1'b1;
        mm_is_legal = 1'b1;
        mm_data     = 20'd300;
        out_ready   = 1'b0;
        @(negedge clk);
        check("fp staged count", {27'd0, fifo_count}, 32'd16);
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clk);
        check("fp push+pop count", {27'd0, fifo_count}, 32'd16);
        check("fp overflow",       {31'd0, overflow},   32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fp drain%0d data", i), {12'd0, out_data},
                  (i < 15) ? 32'(201 + i) : 32'd300);
            @(negedge clk);
        end
        check("fp drained", {27'd0, fifo_count}, 32'd0);

        // ---------------- overflow: two frames, no reads ----------------
        out_ready = 1'b0;
        send_frame(4, 4, 400, 1'b0);
        send_frame(4, 4, 500, 1'b0);
        check("ov fifo_count", {27'd0, fifo_count}, 32'd16);
        check("ov overflow",   {31'd0, overflow},   32'd1);
        check_head("ov head", 20'd400, 2'd0, 2'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) begin
            @(negedge clk);
        end
        check("ov drained", {27'd0, fifo_count}, 32'd0);
        check("ov sticky",  {31'd0, overflow},   32'd1);

        // ---------------- reset mid-frame ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mm_valid      = 1'b1;
            mm_is_legal   = 1'b1;
            mm_data       = 20'(600 + i);
            mm_change_row = (i == 2);
            @(negedge clk);
        end
        check("rm pre-reset count", {27'd0, fifo_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rm async out_valid",  {31'd0, out_valid},  32'd0);
        check("rm async fifo_count", {27'd0, fifo_count}, 32'd0);
        check("rm async overflow",   {31'd0, overflow},   32'd0);
        check("rm async out_data",   {12'd0, out_data},   32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        mm_valid    = 1'b1;
        mm_is_legal = 1'b1;
        mm_data     = 20'd77;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("rm fifo_count", {27'd0, fifo_count}, 32'd1);
        check_head("rm fresh", 20'd77, 2'd0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("rm no extra", {27'd0, fifo_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_result_collector.md
MM_RESULT_COLLECTOR -- requirements
Module: mm_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning result FIFO depth in entries (power of two, minimum 16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port mm_valid  input  1  result strobe from the matrix multiplier.
REQ-005 SHALL have port mm_data  input  20  signed result element, two's complement.
REQ-006 SHALL have port mm_change_row  input  1  high with the last element of each result row.
REQ-007 SHALL have port mm_is_legal  input  1  low for one cycle, together with mm_valid, when the dimension check failed.
REQ-008 SHALL have port out_ready  input  1  host accepts the head entry.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have ports out_data  output  20, out_row  output  2, out_col  output  2: element value and its 0-based position.
REQ-011 SHALL have ports out_last  output  1 and out_illegal  output  1: end-of-matrix marker and illegal-result marker.
REQ-012 SHALL have ports fifo_count  output  clog2(DEPTH)+1  occupancy and overflow  output  1  sticky drop flag.

Function
REQ-013 SHALL define a legal sample as mm_valid=1 with mm_is_legal=1, and an illegal sample as mm_valid=1 with mm_is_legal=0; no sample is taken when mm_valid=0.
REQ-014 SHALL, on a legal sample, load one staging register with {mm_data, row counter, col counter, illegal=0}.
REQ-015 SHALL, on an illegal sample, load staging with {data=0, row=0, col=0, illegal=1} and clear both row and col counters.
REQ-016 SHALL, after a legal sample with mm_change_row=1, set col to 0 and increment row; otherwise it SHALL increment col. Both counters SHALL be 2 bits and wrap modulo 4.
REQ-017 SHALL, in every cycle the staging register is occupied, push the staged entry into the FIFO on that edge.
REQ-018 SHALL set the pushed entry's last bit to 1 when the staged entry is illegal or the current cycle carries no legal sample; otherwise last SHALL be 0.
REQ-019 SHALL clear row and col when it pushes an entry with last=1.
REQ-020 SHALL leave staging empty after the push when no sample arrives in the same cycle; when a sample does arrive, staging SHALL reload in the same edge, so staging and push operate back to back.
REQ-021 SHALL give a fixed latency: a sample at edge t enters staging, is pushed at edge t+1, and appears with out_valid=1 after edge t+1 if the FIFO was empty. The FIFO SHALL have no bypass path.
REQ-022 SHALL drive out_* combinationally from the FIFO head; out_valid SHALL equal fifo_count!=0.
REQ-023 SHALL pop the head on out_valid & out_ready; with out_valid=0, out_ready SHALL be ignored.
REQ-024 SHALL, on a push while full, accept the push if a pop occurs in the same cycle; otherwise it SHALL drop the entry and set overflow=1.
REQ-025 SHALL keep overflow set until reset.
REQ-026 SHALL keep fifo_count unchanged on a simultaneous push and pop; it SHALL never exceed DEPTH or go below 0.
REQ-027 SHALL hold out_data and all other out_* stable while out_valid=1 and out_ready=0.
REQ-028 SHALL push nothing spurious when mm_change_row=1 with mm_valid=0; that input is ignored.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously empty the FIFO and staging, clear row, col and overflow, and force out_valid=0 and fifo_count=0.
REQ-030 SHALL drive out_data, out_row, out_col, out_last and out_illegal to 0 during reset.
REQ-031 SHALL discard any in-flight entries on reset asserted mid-frame, with no partial last emitted afterwards.
REQ-032 SHALL take its first sample at the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover a 2x2 result: data 5,-3,7,9 on 4 consecutive cycles, change_row on the 2nd and 4th, out_ready=1 -> (5,0,0,last0), (-3,0,1,0), (7,1,0,0), (9,1,1,last1), first out_valid 2 edges after the first mm_valid.
REQ-034 SHALL cover an illegal sample: mm_valid=1 and mm_is_legal=0 for one cycle -> a single entry with data 0, out_illegal=1, out_last=1, row/col 0.
REQ-035 SHALL cover backpressure: 4x4 frame (16 results) with out_ready=0 -> fifo_count=16, overflow=0, all outputs stable; then out_ready=1 -> 16 in-order pops, the 16th has row=3, col=3, last=1.
REQ-036 SHALL cover overflow: two 4x4 frames with out_ready=0 -> fifo_count stays 16, overflow=1, the head is still frame 1 element (0,0).
REQ-037 SHALL cover full with simultaneous push and pop: FIFO full, out_ready=1 during a push -> no drop, fifo_count stays 16, overflow stays 0.
REQ-038 SHALL cover reset mid-frame: rst_n low after 3 of 9 results -> fifo_count=0 and out_valid=0 immediately; a fresh 1x1 frame afterwards -> (value,0,0,last1).
